// File: rtl/hall_call_panel.sv
// rtl/hall_call_panel.sv - hall-call button front end: sync, debounce, press filter, lamp hold.
// Each of the 2*FLOORS buttons is an independent channel; channel c >= FLOORS is a down button.
module hall_call_panel #(
    parameter int FLOORS   = 6,
    parameter int FW       = 3,
    parameter int DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:FLOORS-1] raw_up,
    input  logic [0:FLOORS-1] raw_down,
    input  logic              svc_valid,
    input  logic [0:FW-1]     svc_floor,
    input  logic              svc_dir,
    output logic [0:FLOORS-1] req_up,
    output logic [0:FLOORS-1] req_down,
    output logic [0:FLOORS-1] lamp_up,
    output logic [0:FLOORS-1] lamp_down
);

    localparam int NCH = 2 * FLOORS;

    logic [NCH-1:0] w_req;
    logic [NCH-1:0] w_lamp;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam int F     = c % FLOORS;
        localparam bit DN    = (c >= FLOORS);
        localparam bit VALID = DN ? (F != 0) : (F != FLOORS - 1);

        logic       w_raw;
        logic       w_deb_next;
        logic       w_press;
        logic       w_clr;
        logic       w_req_next;
        logic       r_s1;
        logic       r_s2;
        logic       r_deb;
        logic [3:0] r_cnt;
        logic       r_req;
        logic       r_lamp;

        assign w_raw      = DN ? raw_down[F] : raw_up[F];
        assign w_deb_next = (r_s2 != r_deb && r_cnt == 4'(DEBOUNCE - 1)) ? r_s2 : r_deb;
        assign w_press    = w_deb_next & ~r_deb;
        assign w_clr      = svc_valid & (svc_dir == DN) & (svc_floor == FW'(F));
        // Invalid buttons still debounce but can never request, so their lamp stays 0.
        assign w_req_next = w_press & VALID & ~r_lamp & ~w_clr;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1   <= 1'b0;
                r_s2   <= 1'b0;
                r_deb  <= 1'b0;
                r_cnt  <= 4'd0;
                r_req  <= 1'b0;
                r_lamp <= 1'b0;
            end else begin
                r_s1  <= w_raw;
                r_s2  <= r_s1;
                r_deb <= w_deb_next;
                if (r_s2 == r_deb) begin
                    r_cnt <= 4'd0;
                end else if (r_cnt == 4'(DEBOUNCE - 1)) begin
                    r_cnt <= 4'd0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
                r_req  <= w_req_next;
                r_lamp <= (r_lamp | w_req_next) & ~w_clr;
            end
        end

        assign w_req[c]  = r_req;
        assign w_lamp[c] = r_lamp;
    end

    for (genvar f = 0; f < FLOORS; f++) begin : g_out
        assign req_up[f]    = w_req[f];
        assign req_down[f]  = w_req[FLOORS+f];
        assign lamp_up[f]   = w_lamp[f];
        assign lamp_down[f] = w_lamp[FLOORS+f];
    end

endmodule

// File: tb/tb_hall_call_panel.sv
// tb/tb_hall_call_panel.sv - scoreboard bench for hall_call_panel with a sliding-window reference model.
module tb_hall_call_panel;

    localparam int FLOORS   = 6;
    localparam int FW       = 3;
    localparam int DEBOUNCE = 4;
    localparam int NCH      = 2 * FLOORS;
    localparam int OW       = 4 * FLOORS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [0:FLOORS-1] raw_up = '0;
    logic [0:FLOORS-1] raw_down = '0;
    logic              svc_valid = 1'b0;
    logic [0:FW-1]     svc_floor = '0;
    logic              svc_dir = 1'b0;
    logic [0:FLOORS-1] req_up;
    logic [0:FLOORS-1] req_down;
    logic [0:FLOORS-1] lamp_up;
    logic [0:FLOORS-1] lamp_down;

    hall_call_panel #(.FLOORS(FLOORS), .FW(FW), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk), .rst_n(rst_n),
        .raw_up(raw_up), .raw_down(raw_down),
        .svc_valid(svc_valid), .svc_floor(svc_floor), .svc_dir(svc_dir),
        .req_up(req_up), .req_down(req_down),
        .lamp_up(lamp_up), .lamp_down(lamp_down)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [OW-1:0] exp_q[$];

    // Reference model: raw samples per edge; the debounced level flips once the
    // DEBOUNCE most recent synchronised samples all disagree with it.
    bit samp[NCH][DEBOUNCE+2];
    bit m_deb[NCH];
    bit m_lamp[NCH];
    bit m_req[NCH];

    always @(posedge clk) begin
        int f;
        bit dn, lvl, all_diff, press, valid, clr;
        logic [0:FLOORS-1] eu, ed, lu, ld;
        for (int c = 0; c < NCH; c++) begin
            if (!rst_n) begin
                for (int i = 0; i < DEBOUNCE + 2; i++) samp[c][i] = 1'b0;
                m_deb[c] = 0; m_lamp[c] = 0; m_req[c] = 0;
            end else begin
                f   = c % FLOORS;
                dn  = (c >= FLOORS);
                lvl = dn ? raw_down[f] : raw_up[f];
                for (int i = DEBOUNCE + 1; i > 0; i--) samp[c][i] = samp[c][i-1];
                samp[c][0] = lvl;
                all_diff = 1;
                for (int i = 2; i <= DEBOUNCE + 1; i++)
                    if (samp[c][i] == m_deb[c]) all_diff = 0;
                press = all_diff && !m_deb[c];
                if (all_diff) m_deb[c] = !m_deb[c];
                valid = dn ? (f != 0) : (f != FLOORS - 1);
                clr = svc_valid && (svc_dir == dn) && (int'(svc_floor) == f);
                m_req[c]  = press && valid && !m_lamp[c] && !clr;
                m_lamp[c] = (m_lamp[c] || m_req[c]) && !clr;
            end
        end
        for (int k = 0; k < FLOORS; k++) begin
            eu[k] = m_req[k];  ed[k] = m_req[FLOORS+k];
            lu[k] = m_lamp[k]; ld[k] = m_lamp[FLOORS+k];
        end
        exp_q.push_back({eu, ed, lu, ld});
    end

    always @(negedge clk) begin
        logic [OW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({req_up, req_down, lamp_up, lamp_down} !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t got req_up=%b req_down=%b lamp_up=%b lamp_down=%b expected %b",
                         $time, req_up, req_down, lamp_up, lamp_down, e);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic svc_pulse(input int fl, input bit dir);
        svc_valid = 1'b1; svc_floor = FW'(fl); svc_dir = dir;
        @(negedge clk);
        svc_valid = 1'b0;
    endtask

    int hold[NCH];

    initial begin
        cycles(3);
        rst_n = 1'b1;
        cycles(3);

        // Clean press.
        raw_up[2] = 1'b1; cycles(20); raw_up[2] = 1'b0; cycles(10);

        // Glitch rejection, then an accepted pulse.
        raw_down[3] = 1'b1; cycles(3); raw_down[3] = 1'b0; cycles(10);
        raw_down[3] = 1'b1; cycles(5); raw_down[3] = 1'b0; cycles(10);

        // Duplicate suppression, service clear, re-press.
        raw_up[1] = 1'b1; cycles(8); raw_up[1] = 1'b0; cycles(8);
        raw_up[1] = 1'b1; cycles(8); raw_up[1] = 1'b0; cycles(8);
        svc_pulse(1, 1'b0); cycles(2);
        raw_up[1] = 1'b1; cycles(8); raw_up[1] = 1'b0; cycles(8);

        // Invalid buttons, press/service collision, out-of-range floor.
        raw_up[5] = 1'b1; raw_down[0] = 1'b1; cycles(10);
        raw_up[5] = 1'b0; raw_down[0] = 1'b0;
        raw_up[4] = 1'b1; cycles(5);
        svc_pulse(4, 1'b0); cycles(6); raw_up[4] = 1'b0; cycles(8);
        svc_pulse(7, 1'b0); svc_pulse(7, 1'b1); cycles(2);

        // Reset mid-operation with lamps lit and a count in flight.
        raw_up[0] = 1'b1; raw_down[4] = 1'b1; cycles(8);
        raw_up[0] = 1'b0; raw_down[4] = 1'b0;
        raw_up[2] = 1'b1; cycles(3);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({req_up, req_down, lamp_up, lamp_down} !== '0) begin
            miscompares++;
            $display("FAIL async_reset got %b expected all zero", {req_up, req_down, lamp_up, lamp_down});
        end
        cycles(2);
        rst_n = 1'b1;
        cycles(12);
        raw_up[2] = 1'b0; cycles(8);

        // Randomised traffic.
        for (int c = 0; c < NCH; c++) hold[c] = $urandom_range(1, 9);
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < NCH; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    hold[c] = $urandom_range(1, 9);
                    if (c < FLOORS) raw_up[c] = ~raw_up[c];
                    else raw_down[c-FLOORS] = ~raw_down[c-FLOORS];
                end
            end
            svc_valid = ($urandom_range(0, 3) == 0);
            svc_floor = FW'($urandom_range(0, 7));
            svc_dir   = 1'($urandom_range(0, 1));
            cycles(1);
        end
        svc_valid = 1'b0;
        raw_up = '0; raw_down = '0;
        cycles(12);

        vectors++;
        if (exp_q.size() > 1) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d pending expected at most 1", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
